conv_stream_param: RTL and testbench
====================================

// Module: conv_stream_param
// PURPOSE
//  Parametrised streaming 1-D valid convolution: y[k] = sum_{j<F} x[k+j]*f[j], k = 0..X-F.
//  Successor of the fixed-size ROM-filter conv blocks:
//   - filter coefficients are loaded over a stream, not a ROM; they can be reloaded between vectors.
//   - T, X and F are generic; ReLU is a parameter.
//  Sits between an upstream x/f producer and a downstream y consumer, all using valid/ready.
// PARAMETERS
//  T     16  data width of x, f and y (signed, two's complement)
//  X     32  input vector length (>= F)
//  F     4   filter taps (>= 2)
//  RELU  1   1: negative results are output as 0; 0: results are passed through signed
// PORTS
//  clk      in   1  clock, rising edge
//  reset    in   1  asynchronous, active-low reset
//  f_data   in   T  coefficient word, f[0] first
//  f_valid  in   1  coefficient word valid
//  f_ready  out  1  coefficient word accepted when f_valid & f_ready
//  f_load   in   1  request a coefficient reload; sampled only in S_LOAD_X while no x word has been taken yet
//  x_data   in   T  input sample, x[0] first
//  x_valid  in   1  input sample valid
//  x_ready  out  1  input sample accepted when x_valid & x_ready
//  y_data   out  T  result word
//  y_valid  out  1  result valid; held until y_ready
//  y_ready  in   1  consumer ready
// BEHAVIOUR
//  Reset (reset=0, async): state S_LOAD_F, all counters 0, accumulator 0.
//   Outputs: f_ready=1, x_ready=0, y_valid=0, y_data=0. Coefficient and x memories are not cleared.
//  States and transitions:
//   S_LOAD_F: f_ready=1. Stores f[cnt_f] per f handshake; after the F-th word -> S_LOAD_X.
//   S_LOAD_X: x_ready=1. Stores x[cnt_x] per x handshake; after the X-th word -> S_CALC.
//    f_load=1 with cnt_x==0 -> S_LOAD_F (x_ready=0 that cycle); f_load is ignored once cnt_x>0.
//   S_CALC: f_ready=0, x_ready=0. Issues F synchronous reads of x[k+j] and f[j] (1-cycle read latency).
//    Products pass one pipeline register before accumulation; after the last product is accumulated -> S_OUT.
//   S_OUT: y_valid=1 and y_data stable until y_ready=1.
//    On handshake: k==X-F -> S_LOAD_X (k=0, cnt_x=0, coefficients retained); else k++, clear accumulator -> S_CALC.
//  Latency:
//   - first y_valid rises exactly F+3 cycles after the clock edge accepting x[X-1];
//   - each later y_valid rises F+3 cycles after the previous y handshake.
//  Throughput: one result per F+3 cycles plus consumer stall; no overlap of loading and computing.
//  Arithmetic:
//   - product is full 2T bits, saturated to [-2^(T-1), 2^(T-1)-1] before the pipeline register;
//   - accumulation is done in T+1 bits and re-saturated to T bits every step (saturation is sticky-free: a later negative term can pull it back).
//   - RELU applies only at y_data.
//  Boundaries:
//   - x_valid during S_LOAD_F/S_CALC/S_OUT and f_valid outside S_LOAD_F are not accepted (ready=0) and must not disturb state.
//   - y_ready high before y_valid has no effect.
//   - Reset asserted mid-vector or mid-output returns to S_LOAD_F immediately; partial data is discarded and y_valid drops asynchronously.
//   - X==F yields exactly one result per vector.
// STRUCTURE
//  conv_pkg: state enum (S_LOAD_F, S_LOAD_X, S_CALC, S_OUT), function sat(value, T) -> T-bit saturated value.
//  Sub-module conv_mac_sat: product saturation, pipeline register, saturating accumulator with clear/enable, ReLU stage.
//  x and f storage are inferred single-port synchronous RAMs (depth X and F) inside this module.
//  Top level holds the FSM, counters (cnt_f, cnt_x, k, tap) sized $clog2 of their range plus 1 where a terminal compare needs it.
// TESTING
//  1. T=16,X=32,F=4: f=[1,2,3,4], x[i]=i, y_ready=1 -> 29 outputs y[k]=10k+20 (20,30,...,300); first one F+3=7 cycles after x[31].
//  2. Same vector, y_ready toggled 1-in-3 -> identical 29 values; y_data stable while y_valid&!y_ready.
//  3. f=[32767]*4, x=[32767]*32 -> every y=32767; f=[-32768]*4, x=[32767]*32, RELU=0 -> every y=-32768.
//  4. f=[-1,-1,-1,-1], x=[1]*32: RELU=0 -> 29 outputs of -4; RELU=1 -> 29 outputs of 0.
//  5. Second vector without f_load reuses coefficients (same as test 1).
//     f_load=1 then f=[4,3,2,1] with x[i]=i -> y[k]=10k+10.
//  6. Assert reset during S_CALC of the 5th output -> y_valid=0, f_ready=1 immediately.
//     A new f/x load then gives the exact test-1 results.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and helpers for the streaming convolution block.
package conv_pkg;

  typedef enum logic [1:0] {S_LOAD_F, S_LOAD_X, S_CALC, S_OUT} state_t;

  // Clamp a sign-extended value to the signed range of a w-bit word.
  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/conv_mac_sat.sv
// Saturating multiply-accumulate lane: product register, T+1-bit accumulate
// re-clamped to T bits every step, and an optional ReLU on the output register.
module conv_mac_sat
  import conv_pkg::*;
#(
  parameter int T    = 16,
  parameter int RELU = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [T-1:0] x,
  input  logic [T-1:0] f,
  input  logic         prod_en,
  input  logic         acc_clr,
  input  logic         acc_en,
  input  logic         out_en,
  output logic [T-1:0] y
);

  logic signed [2*T-1:0] prod_full;
  logic signed [T:0]     acc_sum;
  logic        [T-1:0]   prod_sat, acc_sat;
  logic signed [T-1:0]   prod_q, acc;

  assign prod_full = $signed(x) * $signed(f);
  assign prod_sat  = T'(sat(64'(prod_full), T));
  assign acc_sum   = {acc[T-1], acc} + {prod_q[T-1], prod_q};
  // Clamp every step so a later opposite-sign term can pull the sum back.
  assign acc_sat   = T'(sat(64'(acc_sum), T));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prod_q <= '0;
      acc    <= '0;
      y      <= '0;
    end else begin
      if (prod_en) prod_q <= prod_sat;
      if (acc_clr)     acc <= '0;
      else if (acc_en) acc <= acc_sat;
      if (out_en) y <= ((RELU != 0) && acc[T-1]) ? '0 : acc;
    end
  end

endmodule

// File: rtl/conv_stream_param.sv
// Streaming 1-D valid convolution with stream-loaded, reloadable coefficients.
// Loads F taps, then X samples, then emits X-F+1 results one at a time.
module conv_stream_param
  import conv_pkg::*;
#(
  parameter int T    = 16,
  parameter int X    = 32,
  parameter int F    = 4,
  parameter int RELU = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [T-1:0] f_data,
  input  logic         f_valid,
  output logic         f_ready,
  input  logic         f_load,
  input  logic [T-1:0] x_data,
  input  logic         x_valid,
  output logic         x_ready,
  output logic [T-1:0] y_data,
  output logic         y_valid,
  input  logic         y_ready
);

  localparam int AW_X = $clog2(X);
  localparam int AW_F = $clog2(F);
  localparam int CW_X = $clog2(X + 1);
  localparam int CW_F = $clog2(F + 1);
  localparam logic [CW_X-1:0] X_LAST = CW_X'(X - 1);
  localparam logic [CW_X-1:0] K_LAST = CW_X'(X - F);
  localparam logic [CW_F-1:0] F_LAST = CW_F'(F - 1);
  localparam logic [CW_F-1:0] F_N    = CW_F'(F);

  state_t          state;
  logic [CW_F-1:0] cnt_f, tap;
  logic [CW_X-1:0] cnt_x, k;
  logic [2:0]      vld_pipe;
  logic [T-1:0]    x_mem [X];
  logic [T-1:0]    f_mem [F];
  logic [T-1:0]    x_rd, f_rd;
  logic [AW_X-1:0] x_addr;
  logic [AW_F-1:0] f_addr;
  logic            reload, f_hs, x_hs, y_hs, issue, calc_done;

  assign reload    = (state == S_LOAD_X) && f_load && (cnt_x == '0);
  assign f_ready   = (state == S_LOAD_F);
  assign x_ready   = (state == S_LOAD_X) && !reload;
  assign f_hs      = f_valid && f_ready;
  assign x_hs      = x_valid && x_ready;
  assign y_hs      = y_valid && y_ready;
  assign issue     = (state == S_CALC) && (tap != F_N);
  // Last product has been accumulated once the pipe tail drains behind it.
  assign calc_done = (state == S_CALC) && (tap == F_N) && vld_pipe[2] && !vld_pipe[1];

  assign x_addr = (state == S_CALC) ? AW_X'(k + CW_X'(tap)) : AW_X'(cnt_x);
  assign f_addr = (state == S_CALC) ? AW_F'(tap) : AW_F'(cnt_f);

  always_ff @(posedge clk) begin
    if (x_hs) x_mem[x_addr] <= x_data;
    x_rd <= x_mem[x_addr];
  end

  always_ff @(posedge clk) begin
    if (f_hs) f_mem[f_addr] <= f_data;
    f_rd <= f_mem[f_addr];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_LOAD_F;
      cnt_f    <= '0;
      cnt_x    <= '0;
      k        <= '0;
      tap      <= '0;
      vld_pipe <= '0;
      y_valid  <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[1:0], issue};
      case (state)
        S_LOAD_F: if (f_hs) begin
          if (cnt_f == F_LAST) begin
            cnt_f <= '0;
            state <= S_LOAD_X;
          end else cnt_f <= cnt_f + CW_F'(1);
        end
        S_LOAD_X: begin
          if (reload) state <= S_LOAD_F;
          else if (x_hs) begin
            if (cnt_x == X_LAST) state <= S_CALC;
            else cnt_x <= cnt_x + CW_X'(1);
          end
        end
        S_CALC: begin
          if (issue) tap <= tap + CW_F'(1);
          if (calc_done) begin
            state   <= S_OUT;
            y_valid <= 1'b1;
          end
        end
        S_OUT: if (y_hs) begin
          y_valid <= 1'b0;
          tap     <= '0;
          if (k == K_LAST) begin
            k     <= '0;
            cnt_x <= '0;
            state <= S_LOAD_X;
          end else begin
            k     <= k + CW_X'(1);
            state <= S_CALC;
          end
        end
        default: state <= S_LOAD_F;
      endcase
    end
  end

  conv_mac_sat #(.T(T), .RELU(RELU)) u_mac (
    .clk     (clk),
    .reset   (reset),
    .x       (x_rd),
    .f       (f_rd),
    .prod_en (vld_pipe[0]),
    .acc_clr (y_hs),
    .acc_en  (vld_pipe[1]),
    .out_en  (calc_done),
    .y       (y_data)
  );

endmodule

// File: tb/tb_conv_stream_param.sv
// Scoreboard bench: two instances (ReLU on / off) share stimulus; a monitor
// pops expected results on every y handshake and checks latency and stall stability.
module tb_conv_stream_param;
  localparam int T = 16, X = 32, F = 4, NOUT = X - F + 1;

  logic clk = 1'b0, reset = 1'b0;
  logic [T-1:0] f_data = '0, x_data = '0;
  logic f_valid = 1'b0, x_valid = 1'b0, f_load = 1'b0, y_ready = 1'b1;
  logic f_ready, x_ready, y_valid, f_ready0, x_ready0, y_valid0;
  logic signed [T-1:0] y_data, y_data0;

  int q1[$], q0[$];
  int n_tests = 0, n_fail = 0, cyc = 0, t_x = 0, t_hs = 0, out_cnt = 0;
  bit rmode = 1'b0;

  conv_stream_param #(.T(T), .X(X), .F(F), .RELU(1)) u_relu (
    .clk(clk), .reset(reset), .f_data(f_data), .f_valid(f_valid), .f_ready(f_ready),
    .f_load(f_load), .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready),
    .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready));

  conv_stream_param #(.T(T), .X(X), .F(F), .RELU(0)) u_lin (
    .clk(clk), .reset(reset), .f_data(f_data), .f_valid(f_valid), .f_ready(f_ready0),
    .f_load(f_load), .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready0),
    .y_data(y_data0), .y_valid(y_valid0), .y_ready(y_ready));

  always #5 clk = ~clk;
  initial forever @(posedge clk) cyc++;
  initial forever begin
    @(posedge clk); #2;
    y_ready = rmode ? (cyc % 3 == 0) : 1'b1;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++; n_fail++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  // Monitor / scoreboard
  initial begin
    int prev_d, e, tref;
    bit prev_v, prev_r;
    prev_v = 0; prev_r = 0; prev_d = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin prev_v = 0; continue; end
      if (y_valid && !prev_v) begin
        tref = (t_x > t_hs) ? t_x : t_hs;
        chk("latency", cyc - tref, F + 3);
      end
      if (prev_v && !prev_r && y_valid) chk("stall_stable", y_data, prev_d);
      if (y_valid && y_ready) begin
        if (q1.size() == 0) timeout("unexpected_y_relu");
        else begin e = q1.pop_front(); chk("y_relu", y_data, e); end
        if (!y_valid0 || q0.size() == 0) timeout("missing_or_unexpected_y_lin");
        else begin e = q0.pop_front(); chk("y_lin", y_data0, e); end
        t_hs = cyc + 1;
        out_cnt++;
      end
      prev_v = y_valid; prev_r = y_ready; prev_d = y_data;
    end
  end

  task automatic send_f(input int v);
    int n = 0;
    f_data = 16'(v); f_valid = 1'b1;
    @(negedge clk);
    while (!f_ready && n < 5000) begin @(negedge clk); n++; end
    if (n >= 5000) timeout("send_f");
    @(posedge clk); #1 f_valid = 1'b0;
  endtask

  task automatic send_x(input int v, input bit last);
    int n = 0;
    x_data = 16'(v); x_valid = 1'b1;
    @(negedge clk);
    while (!x_ready && n < 5000) begin @(negedge clk); n++; end
    if (n >= 5000) timeout("send_x");
    if (last) t_x = cyc + 1;
    @(posedge clk); #1 x_valid = 1'b0;
  endtask

  task automatic load_f(input int a0, input int a1, input int a2, input int a3);
    send_f(a0); send_f(a1); send_f(a2); send_f(a3);
  endtask

  task automatic load_x_ramp();
    for (int i = 0; i < X; i++) send_x(i, i == X - 1);
  endtask

  task automatic load_x_const(input int v);
    for (int i = 0; i < X; i++) send_x(v, i == X - 1);
  endtask

  task automatic push_lin(input int base, input int n);
    for (int kk = 0; kk < n; kk++) begin q1.push_back(10*kk + base); q0.push_back(10*kk + base); end
  endtask

  task automatic push_const(input int v1, input int v0);
    for (int kk = 0; kk < NOUT; kk++) begin q1.push_back(v1); q0.push_back(v0); end
  endtask

  task automatic drain();
    int n = 0;
    while ((q1.size() != 0 || q0.size() != 0 || y_valid) && n < 5000) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 5000) timeout("drain");
  endtask

  task automatic reload();
    f_load = 1'b1;
    @(negedge clk);
    chk("x_ready_during_f_load", x_ready, 0);
    @(posedge clk); #1 f_load = 1'b0;
    @(negedge clk);
    chk("f_ready_after_f_load", f_ready, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int oc0, n;
    #12;
    chk("rst_f_ready", f_ready, 1);
    chk("rst_x_ready", x_ready, 0);
    chk("rst_y_valid", y_valid, 0);
    chk("rst_y_data", y_data, 0);
    @(posedge clk); #1 reset = 1'b1;

    // x offered while loading coefficients must be ignored
    x_valid = 1'b1; x_data = 16'h1234;
    @(negedge clk); chk("x_ready_in_load_f", x_ready, 0);
    @(posedge clk); #1 x_valid = 1'b0;
    load_f(1, 2, 3, 4);
    f_valid = 1'b1; f_data = 16'd77;
    @(negedge clk); chk("f_ready_in_load_x", f_ready, 0);
    @(posedge clk); #1 f_valid = 1'b0;

    push_lin(20, NOUT); load_x_ramp(); drain();

    rmode = 1'b1;
    push_lin(20, NOUT); load_x_ramp(); drain();
    rmode = 1'b0;

    reload(); load_f(4, 3, 2, 1);
    push_lin(10, NOUT); load_x_ramp(); drain();

    reload(); load_f(32767, 32767, 32767, 32767);
    push_const(32767, 32767); load_x_const(32767); drain();

    reload(); load_f(-32768, -32768, -32768, -32768);
    push_const(0, -32768); load_x_const(32767); drain();

    // clamp to max, then negative term pulls back: 32767 -> -1 -> 32766
    reload(); load_f(32767, 32767, -32768, 1);
    push_const(32766, 32766); load_x_const(32767); drain();

    reload(); load_f(-1, -1, -1, -1);
    push_const(0, -4); load_x_const(1); drain();

    // reset during computation of the 5th result
    reload(); load_f(1, 2, 3, 4);
    push_lin(20, 4);
    oc0 = out_cnt;
    load_x_ramp();
    n = 0;
    while (out_cnt < oc0 + 4 && n < 5000) begin @(posedge clk); n++; end
    if (n >= 5000) timeout("wait_4_outputs");
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("midrst_y_valid", y_valid, 0);
    chk("midrst_y_valid_lin", y_valid0, 0);
    chk("midrst_f_ready", f_ready, 1);
    chk("midrst_x_ready", x_ready, 0);
    chk("midrst_queue_empty", q1.size(), 0);
    @(posedge clk); @(posedge clk); #1 reset = 1'b1;
    load_f(1, 2, 3, 4);
    push_lin(20, NOUT); load_x_ramp(); drain();

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
